// File: rtl/vic_irq_sequencer_if.sv
// Signal bundle between the Vic / core pipeline and the interrupt entry/return sequencer.
interface vic_irq_sequencer_if #(
    parameter int AW = 32
);
    logic          i_VIC_ctrl;
    logic [AW-1:0] i_VIC_iaddr;
    logic [AW-1:0] i_PC;
    logic [3:0]    i_CCodes;
    logic          i_reti_dec;
    logic          i_stall;
    logic          o_pc_sel;
    logic [AW-1:0] o_pc_target;
    logic          o_flush;
    logic [3:0]    o_CCodes;
    logic          o_CCodes_we;
    logic          o_reti;
    logic [3:0]    o_depth;
    logic          o_err;

    modport master (
        output i_VIC_ctrl, i_VIC_iaddr, i_PC, i_CCodes, i_reti_dec, i_stall,
        input  o_pc_sel, o_pc_target, o_flush, o_CCodes, o_CCodes_we, o_reti, o_depth, o_err
    );

    modport slave (
        input  i_VIC_ctrl, i_VIC_iaddr, i_PC, i_CCodes, i_reti_dec, i_stall,
        output o_pc_sel, o_pc_target, o_flush, o_CCodes, o_CCodes_we, o_reti, o_depth, o_err
    );
endinterface

// File: rtl/vic_irq_sequencer.sv
// Interrupt entry/return sequencer: saves {PC, NZCV} on a LIFO nesting stack on entry,
// restores them on RETI and redirects fetch in both directions.
//
// state | meaning
// IDLE  | nothing in flight; pending RETI wins over pending request
// ENTRY | wait for an unstalled cycle, push {PC, NZCV}, redirect to the ISR vector
// EXIT  | wait for an unstalled cycle, pop, redirect to the saved PC, pulse o_reti
module vic_irq_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    vic_irq_sequencer_if.slave bus
);
    localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_EXIT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic          req_q;
    logic [AW-1:0] vec_q;
    logic          reti_q;
    logic          err_q;
    logic [3:0]    depth_q;
    logic [3:0]    depth_d;
    logic [AW+3:0] stack_q [DEPTH];

    logic          req_any;
    logic          reti_any;
    logic          idle_exit;
    logic          idle_drop;
    logic          idle_entry;
    logic          fire_entry;
    logic          fire_exit;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] pop_idx;
    logic [AW+3:0] top;

    // Pulses arriving this cycle are seen by IDLE directly so the redirect lands one cycle later.
    assign req_any    = req_q  | bus.i_VIC_ctrl;
    assign reti_any   = reti_q | bus.i_reti_dec;
    assign idle_exit  = (state_q == S_IDLE) && reti_any && (depth_q != 4'd0);
    assign idle_drop  = (state_q == S_IDLE) && reti_any && (depth_q == 4'd0);
    assign idle_entry = (state_q == S_IDLE) && !idle_exit && req_any && (depth_q < DEPTH_L);
    assign fire_entry = (state_q == S_ENTRY) && !bus.i_stall;
    assign fire_exit  = (state_q == S_EXIT)  && !bus.i_stall;

    assign push_idx = depth_q[IW-1:0];
    assign pop_idx  = depth_q[IW-1:0] - IW'(1);
    assign top      = stack_q[pop_idx];
    assign depth_d  = depth_q + {3'd0, fire_entry} - {3'd0, fire_exit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (idle_exit) begin
                    state_d = S_EXIT;
                end else if (idle_entry) begin
                    state_d = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (!bus.i_stall) begin
                    state_d = S_IDLE;
                end
            end
            S_EXIT: begin
                if (!bus.i_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_pc_sel    = 1'b0;
        bus.o_flush     = 1'b0;
        bus.o_pc_target = '0;
        bus.o_CCodes    = 4'd0;
        bus.o_CCodes_we = 1'b0;
        bus.o_reti      = 1'b0;
        bus.o_depth     = depth_d;
        bus.o_err       = err_q;
        if (fire_entry) begin
            bus.o_pc_sel    = 1'b1;
            bus.o_flush     = 1'b1;
            bus.o_pc_target = vec_q;
        end else if (fire_exit) begin
            bus.o_pc_sel    = 1'b1;
            bus.o_flush     = 1'b1;
            bus.o_pc_target = top[AW+3:4];
            bus.o_CCodes    = top[3:0];
            bus.o_CCodes_we = 1'b1;
            bus.o_reti      = 1'b1;
        end
    end

    // A pulse coinciding with the consuming strobe stays pending; a RETI at depth 0 is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q   <= 1'b0;
            vec_q   <= '0;
            reti_q  <= 1'b0;
            err_q   <= 1'b0;
            depth_q <= 4'd0;
        end else begin
            req_q   <= bus.i_VIC_ctrl | (req_q & ~fire_entry);
            reti_q  <= ~idle_drop & (bus.i_reti_dec | (reti_q & ~fire_exit));
            depth_q <= depth_d;
            if (bus.i_VIC_ctrl) begin
                vec_q <= bus.i_VIC_iaddr;
            end
            if (idle_drop) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (fire_entry) begin
            stack_q[push_idx] <= {bus.i_PC, bus.i_CCodes};
        end
    end
endmodule

// File: tb/tb_vic_irq_sequencer.sv
// Bench for vic_irq_sequencer: directed scenarios plus random traffic against a queue-based reference.
module tb_vic_irq_sequencer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vic_irq_sequencer_if #(.AW(AW)) bus ();
    vic_irq_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
    endtask

    // reference: stack as queues, plus what redirect (if any) is waiting for an unstalled cycle
    logic [AW-1:0] m_pc[$];
    logic [3:0]    m_cc[$];
    int            m_op;      // 0 none, 1 going into ISR, 2 returning
    bit            m_req, m_reti, m_err;
    logic [AW-1:0] m_vec;

    logic [AW-1:0] pc_drv;
    logic [3:0]    cc_drv;
    bit            redir_prev;
    logic [AW-1:0] tgt_prev;

    logic          l_sel, l_we, l_reti, l_err;
    logic [AW-1:0] l_tgt;
    logic [3:0]    l_cc, l_depth;

    task automatic model_reset();
        m_pc.delete();
        m_cc.delete();
        m_op = 0; m_req = 0; m_reti = 0; m_err = 0; m_vec = '0;
        redir_prev = 0; tgt_prev = '0;
    endtask

    task automatic cyc(input bit ctrl, input logic [AW-1:0] vec, input bit reti, input bit stall);
        bit fire, e_ent, e_ext, drop, r, q;
        logic [AW-1:0] e_tgt;
        logic [3:0] e_cc;
        int e_depth;
        @(negedge clk);
        if (redir_prev) pc_drv = tgt_prev;
        bus.i_VIC_ctrl  = ctrl;
        bus.i_VIC_iaddr = vec;
        bus.i_reti_dec  = reti;
        bus.i_stall     = stall;
        bus.i_PC        = pc_drv;
        bus.i_CCodes    = cc_drv;
        #1;
        fire  = (m_op != 0) && !stall;
        e_ent = fire && (m_op == 1);
        e_ext = fire && (m_op == 2);
        e_tgt = '0;
        e_cc  = '0;
        if (e_ent) e_tgt = m_vec;
        if (e_ext) begin
            e_tgt = m_pc[$];
            e_cc  = m_cc[$];
        end
        e_depth = m_pc.size() + int'(e_ent) - int'(e_ext);
        chk("pc_sel", bus.o_pc_sel, fire);
        chk("flush", bus.o_flush, fire);
        chk("pc_target", bus.o_pc_target, e_tgt);
        chk("ccodes", bus.o_CCodes, e_cc);
        chk("ccodes_we", bus.o_CCodes_we, e_ext);
        chk("reti", bus.o_reti, e_ext);
        chk("depth", bus.o_depth, e_depth);
        chk("err", bus.o_err, m_err);
        l_sel = bus.o_pc_sel; l_tgt = bus.o_pc_target; l_cc = bus.o_CCodes;
        l_we = bus.o_CCodes_we; l_reti = bus.o_reti; l_depth = bus.o_depth; l_err = bus.o_err;

        drop = 0;
        if (fire) begin
            if (m_op == 1) begin
                m_pc.push_back(bus.i_PC);
                m_cc.push_back(bus.i_CCodes);
                m_req = 0;
            end else begin
                void'(m_pc.pop_back());
                void'(m_cc.pop_back());
                m_reti = 0;
            end
            m_op = 0;
        end else if (m_op == 0) begin
            r = m_reti || reti;
            q = m_req || ctrl;
            if (r && m_pc.size() > 0) begin
                m_op = 2;
            end else begin
                if (r) begin
                    m_err = 1; m_reti = 0; drop = 1;
                end
                if (q && m_pc.size() < DEPTH) m_op = 1;
            end
        end
        if (ctrl) begin
            m_req = 1;
            m_vec = vec;
        end
        if (reti && !drop) m_reti = 1;
        redir_prev = fire;
        tgt_prev   = e_tgt;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, '0, 0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sel"}, bus.o_pc_sel, 0);
        chk({tag, "_flush"}, bus.o_flush, 0);
        chk({tag, "_tgt"}, bus.o_pc_target, 0);
        chk({tag, "_cc"}, bus.o_CCodes, 0);
        chk({tag, "_we"}, bus.o_CCodes_we, 0);
        chk({tag, "_reti"}, bus.o_reti, 0);
        chk({tag, "_depth"}, bus.o_depth, 0);
        chk({tag, "_err"}, bus.o_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_VIC_ctrl = 0; bus.i_VIC_iaddr = '0; bus.i_reti_dec = 0; bus.i_stall = 0;
        bus.i_PC = '0; bus.i_CCodes = '0;
        pc_drv = '0; cc_drv = '0;
        model_reset();
        #3;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // single entry / exit
        idle(2);
        pc_drv = 32'h100; cc_drv = 4'b1010;
        cyc(1, 32'h40, 0, 0);
        chk("t1_req_cycle_sel", l_sel, 0);
        cyc(0, '0, 0, 0);
        chk("t1_entry_sel", l_sel, 1);
        chk("t1_entry_tgt", l_tgt, 32'h40);
        chk("t1_entry_depth", l_depth, 1);
        idle(1);
        pc_drv = 32'h48; cc_drv = 4'b0000;
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        chk("t1_exit_tgt", l_tgt, 32'h100);
        chk("t1_exit_cc", l_cc, 4'b1010);
        chk("t1_exit_we", l_we, 1);
        chk("t1_exit_reti", l_reti, 1);
        chk("t1_exit_depth", l_depth, 0);

        // two-level nesting
        idle(1);
        pc_drv = 32'h100;
        cyc(1, 32'h40, 0, 0);
        cyc(0, '0, 0, 0);
        idle(1);
        pc_drv = 32'h44;
        cyc(1, 32'h80, 0, 0);
        cyc(0, '0, 0, 0);
        chk("t2_nest_tgt", l_tgt, 32'h80);
        chk("t2_nest_depth", l_depth, 2);
        idle(1);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        chk("t2_ret1_tgt", l_tgt, 32'h44);
        chk("t2_ret1_depth", l_depth, 1);
        idle(1);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        chk("t2_ret2_tgt", l_tgt, 32'h100);
        chk("t2_ret2_depth", l_depth, 0);

        // stall during entry
        idle(1);
        pc_drv = 32'h300; cc_drv = 4'h5;
        cyc(1, 32'h60, 0, 0);
        for (int i = 0; i < 3; i++) begin
            pc_drv = 32'h304 + 32'(4 * i);
            cyc(0, '0, 0, 1);
            chk("t3_stalled_sel", l_sel, 0);
        end
        pc_drv = 32'h310;
        cyc(0, '0, 0, 0);
        chk("t3_entry_sel", l_sel, 1);
        chk("t3_entry_tgt", l_tgt, 32'h60);
        chk("t3_entry_depth", l_depth, 1);

        // simultaneous RETI and request at depth 1
        idle(1);
        cyc(1, 32'hC0, 1, 0);
        cyc(0, '0, 0, 0);
        chk("t4_exit_tgt", l_tgt, 32'h310);
        chk("t4_exit_cc", l_cc, 4'h5);
        chk("t4_exit_reti", l_reti, 1);
        chk("t4_exit_depth", l_depth, 0);
        cyc(0, '0, 0, 0);
        chk("t4_gap_sel", l_sel, 0);
        cyc(0, '0, 0, 0);
        chk("t4_entry_tgt", l_tgt, 32'hC0);
        chk("t4_entry_depth", l_depth, 1);
        idle(1);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        chk("t4_pushed_restored_pc", l_tgt, 32'h310);

        // full stack
        idle(1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 32'h400 + 32'(16 * i), 0, 0);
            pc_drv = 32'h1000 + 32'(16 * i);
            cyc(0, '0, 0, 0);
        end
        chk("t5_full_depth", l_depth, 4);
        cyc(1, 32'h200, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, '0, 0, 0);
            chk("t5_blocked_sel", l_sel, 0);
            chk("t5_blocked_depth", l_depth, 4);
        end
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        chk("t5_exit_tgt", l_tgt, 32'h1030);
        chk("t5_exit_depth", l_depth, 3);
        cyc(0, '0, 0, 0);
        chk("t5_gap_sel", l_sel, 0);
        cyc(0, '0, 0, 0);
        chk("t5_entry_tgt", l_tgt, 32'h200);
        chk("t5_entry_depth", l_depth, 4);
        for (int i = 0; i < DEPTH; i++) begin
            idle(1);
            cyc(0, '0, 1, 0);
            cyc(0, '0, 0, 0);
        end
        chk("t5_drained_depth", l_depth, 0);

        // RETI at depth 0
        idle(1);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        chk("t6_no_reti", l_reti, 0);
        chk("t6_err_set", l_err, 1);
        idle(2);
        chk("t6_err_sticky", l_err, 1);

        // reset in the middle of an entry
        pc_drv = 32'h700;
        cyc(1, 32'h80, 0, 0);
        cyc(0, '0, 0, 0);
        idle(1);
        cyc(1, 32'h90, 0, 1);
        @(negedge clk);
        bus.i_VIC_ctrl = 0; bus.i_reti_dec = 0; bus.i_stall = 0;
        #1;
        chk("t6_pre_reset_sel", bus.o_pc_sel, 1);
        chk("t6_pre_reset_depth", bus.o_depth, 2);
        rst = 1'b0;
        #1;
        chk_zero("t6_async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk_zero("t6_reset_hold");
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        idle(3);

        // random traffic: first biased toward filling the stack, then toward draining it
        for (int k = 0; k < 500; k++) begin
            pc_drv = $urandom;
            cc_drv = 4'($urandom);
            if (k < 250)
                cyc($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
            else
                cyc($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
